if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch front end: owns the PC and drives the instruction-memory request/response port.
//  Presents {instr, pc+4, flush} each cycle to the IF/ID pipeline register.
//  Absorbs hazard stalls and branch/jump redirects.
//  Squashes wrong-path responses still in flight after a redirect.
// PARAMETERS
//  RESET_PC     10'h000  PC fetched first after reset
//  BUF_DEPTH    2        fetched-instruction buffer entries (>=1)
//  MAX_OUTSTAND 2        max granted-but-unanswered imem requests (>=1)
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   reset, asynchronous, active-high
//  stall          in   1   hazard unit: IF/ID must hold; do not pop
//  redirect_valid in   1   branch/jump taken this cycle
//  redirect_pc    in   10  target byte address; bits[1:0] forced to 0
//  imem_req       out  1   request valid
//  imem_addr      out  10  request byte address
//  imem_gnt       in   1   request accepted this cycle (req&gnt = handshake)
//  imem_rvalid    in   1   response valid; in order, >=1 cycle after its grant
//  imem_rdata     in   32  response instruction
//  instr_out      out  32  instruction to IF/ID; 32'h0 when flush_out=1
//  pc_out         out  10  address of instr_out + 4 (mod 1024)
//  flush_out      out  1   1 = bubble/squash; IF/ID loads NOP
// BEHAVIOUR
//  Reset (async): pc<=RESET_PC, buffer empty, outstanding=0, discard=0, state BOOT.
//   Output values under reset: imem_req=0, imem_addr=RESET_PC, instr_out=0, pc_out=0, flush_out=1.
//  FSM
//   BOOT: one cycle after rst deasserts, imem_req=0; next state FETCH.
//   FETCH -> DRAIN: redirect_valid while any live request is in flight.
//   DRAIN -> FETCH: when discard reaches 0.
//   DRAIN -> DRAIN: a further redirect in DRAIN re-adds the live in-flight count to discard.
//  Issue
//   imem_req=1 in FETCH/DRAIN when (outstanding-discard)+buf_count < BUF_DEPTH and outstanding < MAX_OUTSTAND.
//   imem_addr=pc. On req&gnt: pc<=pc+4 (10-bit wrap 0x3FC->0x000), outstanding++.
//   Ungranted req holds addr stable, except a redirect replaces it the same cycle.
//  Response (imem_rvalid): outstanding--.
//   If discard>0: discard--, data dropped.
//   Otherwise push {instr, pc_of_instr+4}; the buffer never overflows by credit rule (overflow = assertion).
//  Output, combinational from buffer head
//   flush_out = empty | redirect_valid.
//   instr_out/pc_out = head when !flush_out, else 0/0.
//   Pop when !empty & !stall & !redirect_valid.
//   stall with empty buffer: flush_out=1, IF/ID holds per its own stall.
//  Redirect (highest priority, wins over stall/pop)
//   Buffer cleared. pc<=redirect_pc&~3.
//   discard <= outstanding (including a grant in this same cycle) minus a non-discarded response in this same cycle
//   (that response is itself dropped).
//   Request issue at the new pc may start the next cycle; in-order return guarantees correctness.
//  Latency: grant at T, rvalid at T+k -> instr_out valid from T+k+1 (registered buffer), popped same cycle if !stall.
//  Widths: pc arithmetic 10-bit modulo; counters sized $clog2(MAX+1); no saturation needed by construction.
//  Mid-operation reset: all in-flight state discarded; memory responses arriving after rst deasserts while
//   outstanding=0 are ignored (assertion flags them).
// STRUCTURE
//  Package pipeline_pkg: PC_W=10, INSTR_W=32, PC_STEP=4, NOP_INSTR=32'h0, fetch_state_e {BOOT,FETCH,DRAIN},
//   typedef fetch_entry_t {instr, pc_plus4}.
//  Sub-module fetch_buf: sync FIFO of fetch_entry_t, depth BUF_DEPTH, push/pop/clear, count/empty/full.
//  Top holds pc, outstanding, discard, FSM and output muxing.
// TESTING
//  1 Reset, gnt=1 always, 1-cycle rvalid, rdata=addr -> first instr_out=0 with pc_out=4 at cycle 3 after rst drop,
//    then sequential, flush_out=0 steady.
//  2 stall held 4 cycles with buffer full -> imem_req=0, instr_out/pc_out frozen; release -> no instr skipped or duplicated.
//  3 Two requests in flight (0x010,0x014), redirect_pc=0x101 -> both responses dropped, flush_out=1 that cycle,
//    next instr_out is rdata@0x100, pc_out=0x104.
//  4 Redirect coincident with rvalid and with gnt same cycle -> both dropped, discard count correct, DRAIN->FETCH.
//  5 pc wraps: RESET_PC=0x3F8 -> fetch 0x3F8,0x3FC,0x000; pc_out 0x3FC,0x000,0x004.
//  6 rst asserted with 2 outstanding -> outputs reset immediately; late rvalid ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package pipeline_pkg;

  localparam int unsigned PC_W    = 10;
  localparam int unsigned INSTR_W = 32;

  localparam logic [PC_W-1:0]    PC_STEP   = 10'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc_plus4;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  // Next sequential fetch address, 10-bit modulo.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO holding fetched instructions and their pc+4.
module fetch_buf
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [ENTRY_W-1:0]         wdata,
  output logic [ENTRY_W-1:0]         rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= fetch_entry_t'(wdata);
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC ownership, imem request/response handling,
// wrong-path squashing after redirects, and the IF/ID presentation mux.
module if_fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC     = 10'h000,
  parameter int unsigned     BUF_DEPTH    = 2,
  parameter int unsigned     MAX_OUTSTAND = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [9:0]   redirect_pc,
  output logic         imem_req,
  output logic [9:0]   imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  instr_out,
  output logic [9:0]   pc_out,
  output logic         flush_out
);

  localparam int unsigned OCNT_W = $clog2(MAX_OUTSTAND + 1);
  localparam int unsigned BCNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   resp_pc;
  logic [PC_W-1:0]   redirect_aligned;
  logic [OCNT_W-1:0] outstanding;
  logic [OCNT_W-1:0] discard;
  logic [OCNT_W-1:0] outstanding_nxt;
  logic [OCNT_W-1:0] discard_nxt;
  logic [31:0]       credit_used;
  logic              handshake;
  logic              resp_ok;
  logic              resp_keep;
  logic              resp_drop;
  logic              buf_push;
  logic              buf_pop;
  logic              buf_empty;
  logic              buf_full;
  logic [BCNT_W-1:0] buf_count;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;
  logic [ENTRY_W-1:0] head_bits;

  assign redirect_aligned = {redirect_pc[PC_W-1:2], 2'b00};
  assign handshake        = imem_req && imem_gnt;
  assign head             = fetch_entry_t'(head_bits);

  // Counter updates. A redirect turns every request still in flight after
  // this cycle into discard, which also covers re-arming discard in DRAIN
  // (old discard minus this cycle's drop plus the live remainder).
  always_comb begin
    resp_ok         = imem_rvalid && (outstanding != '0);
    resp_drop       = resp_ok && (discard != '0);
    resp_keep       = resp_ok && (discard == '0);
    outstanding_nxt = outstanding + OCNT_W'(handshake) - OCNT_W'(resp_ok);
    discard_nxt     = redirect_valid ? outstanding_nxt
                                     : discard - OCNT_W'(resp_drop);
    credit_used     = 32'(outstanding - discard) + 32'(buf_count);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = FETCH;
      FETCH:   if (redirect_valid && (outstanding_nxt != '0)) state_nxt = DRAIN;
      DRAIN:   if (discard_nxt == '0) state_nxt = FETCH;
      default: state_nxt = BOOT;
    endcase
  end

  // FSM outputs: request issue, buffer control and the IF/ID mux.
  always_comb begin
    imem_req   = (state != BOOT)
              && (credit_used < BUF_DEPTH)
              && (32'(outstanding) < MAX_OUTSTAND);
    imem_addr  = pc;
    flush_out  = buf_empty || redirect_valid;
    instr_out  = flush_out ? NOP_INSTR : head.instr;
    pc_out     = flush_out ? '0 : head.pc_plus4;
    buf_push   = resp_keep && !redirect_valid;
    buf_pop    = !buf_empty && !stall && !redirect_valid;
    push_entry = '{instr: imem_rdata, pc_plus4: pc_inc(resp_pc)};
  end

  // PC, response-address tracker and in-flight counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
      if (redirect_valid)  pc <= redirect_aligned;
      else if (handshake)  pc <= pc_inc(pc);
      if (redirect_valid)  resp_pc <= redirect_aligned;
      else if (resp_keep)  resp_pc <= pc_inc(resp_pc);
    end
  end

  fetch_buf #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (buf_push),
    .pop   (buf_pop),
    .clear (redirect_valid),
    .wdata (push_entry),
    .rdata (head_bits),
    .count (buf_count),
    .empty (buf_empty),
    .full  (buf_full)
  );

  a_no_stray_resp: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> (outstanding != '0));

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(buf_push && buf_full && !buf_pop));

endmodule
